// File: rtl/serial_tx_shifter_if.sv
// Handshake and serial-line bundle for serial_tx_shifter.
// master: the word source (drives load/data, observes status and line).
// slave : the transmitter (observes load/data, drives ready/serial_out/done).
`timescale 100ps/100ps
interface serial_tx_shifter_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             serial_out;
  logic             done;

  modport master (output load, data, input ready, serial_out, done);
  modport slave  (input load, data, output ready, serial_out, done);
endinterface

// File: rtl/serial_tx_shifter.sv
// Parallel-in, serial-out frame transmitter.
// Frame: start bit (0), WIDTH data bits LSB-first, optional even parity, stop (1).
// Each bit is held for CLKS_PER_BIT clocks. The line idles high.
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
`timescale 100ps/100ps
module serial_tx_shifter #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int OUT_DELAY    = 20
) (
  input  logic                 clock,
  input  logic                 clear,
  serial_tx_shifter_if.slave   bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    clk_q,   clk_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic             sout_q,  sout_d;
  logic             ready_q, ready_d;
  logic             done_q,  done_d;
  logic             bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_q,   par_d;
`endif

  assign bit_end = (clk_q == CLK_LAST);

  // State, datapath and output registers; outputs are loaded from next-state
  // values so they change on the same edge as the state they reflect.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= IDLE;
      shift_q <= '0;
      clk_q   <= '0;
      bit_q   <= '0;
      sout_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, counters, shift register and next output values.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    clk_d   = clk_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        clk_d = '0;
        if (bus.load) begin
          shift_d = bus.data;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^bus.data;
`endif
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          clk_d = clk_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          clk_d = clk_q + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          clk_d   = '0;
          state_d = STOP;
        end else begin
          clk_d = clk_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          clk_d = clk_q + CW'(1);
        end
      end
      default: begin
        clk_d   = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  sout_d = par_d;
`endif
      default: sout_d = 1'b1;
    endcase
  end

  assign #(OUT_DELAY) bus.serial_out = sout_q;
  assign #(OUT_DELAY) bus.ready      = ready_q;
  assign #(OUT_DELAY) bus.done       = done_q;

endmodule
